// File: rtl/max_pair_pkg.sv
// rtl/max_pair_pkg.sv - shared constants, result layout and field helpers for the max pair comparator
package max_pair_pkg;

  // Default operand width; pi is 2*W bits, po is W+2 bits.
  localparam int DEFAULT_W = 4;

  // Result field offsets for the default width.
  localparam int MAX_LSB = 0;
  localparam int GT_BIT  = DEFAULT_W;
  localparam int EQ_BIT  = DEFAULT_W + 1;

  // Packed view of po for the default width, msb first: {eq, gt, max}.
  typedef struct packed {
    logic                 eq;
    logic                 gt;
    logic [DEFAULT_W-1:0] max;
  } max_pair_res_t;

  // Field offsets for an arbitrary operand width w.
  function automatic int gt_bit(input int w);
    return w;
  endfunction

  function automatic int eq_bit(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/max_pair_core.sv
// rtl/max_pair_core.sv - combinational unsigned max/compare of two operands (min output under MAX_PAIR_CMP_MIN_OUT_EN)
module max_pair_core
  import max_pair_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] max,
  output logic         gt,
  output logic         eq
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
  ,
  output logic [W-1:0] min
`endif
);

  // Unsigned full-width compare; ties resolve to A so max = A when A >= B.
  always_comb begin
    gt  = (a > b);
    eq  = (a == b);
    max = (a >= b) ? a : b;
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
    min = (a >= b) ? b : a;
`endif
  end

endmodule

// File: rtl/max_pair_cmp_reg.sv
// rtl/max_pair_cmp_reg.sv - registered max/compare of a packed operand pair; optional po_min under MAX_PAIR_CMP_MIN_OUT_EN
module max_pair_cmp_reg
  import max_pair_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  input  logic [2*W-1:0] pi,
  output logic           out_valid,
  output logic [W+1:0]   po
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
  ,
  output logic [W-1:0]   po_min
`endif
);

  localparam int GtBit = gt_bit(W);
  localparam int EqBit = eq_bit(W);

  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] core_max;
  logic         core_gt;
  logic         core_eq;

  logic [W+1:0] po_q;
  logic [W+1:0] po_d;
  logic         out_valid_q;
  logic         out_valid_d;

  assign a = pi[2*W-1:W];
  assign b = pi[W-1:0];

`ifdef MAX_PAIR_CMP_MIN_OUT_EN
  logic [W-1:0] core_min;
  logic [W-1:0] po_min_q;
  logic [W-1:0] po_min_d;
`endif

  max_pair_core #(
    .W (W)
  ) u_core (
    .a   (a),
    .b   (b),
    .max (core_max),
    .gt  (core_gt),
    .eq  (core_eq)
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
    ,
    .min (core_min)
`endif
  );

  // Next state: capture the packed result on in_valid, otherwise hold so pi is ignored.
  always_comb begin
    po_d        = po_q;
    out_valid_d = in_valid;
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
    po_min_d    = po_min_q;
`endif
    if (in_valid) begin
      po_d[MAX_LSB +: W] = core_max;
      po_d[GtBit]        = core_gt;
      po_d[EqBit]        = core_eq;
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
      po_min_d           = core_min;
`endif
    end
  end

  // Result registers; reset clears them at once so an in-flight result is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po_q        <= '0;
      out_valid_q <= 1'b0;
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
      po_min_q    <= '0;
`endif
    end else begin
      po_q        <= po_d;
      out_valid_q <= out_valid_d;
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
      po_min_q    <= po_min_d;
`endif
    end
  end

  assign po        = po_q;
  assign out_valid = out_valid_q;
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
  assign po_min    = po_min_q;
`endif

endmodule

// File: tb/tb_max_pair_cmp_reg.sv
// tb/tb_max_pair_cmp_reg.sv - directed and exhaustive bench for max_pair_cmp_reg (W = 4, MAX_PAIR_CMP_MIN_OUT_EN aware)
module tb_max_pair_cmp_reg;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] pi;
  logic       out_valid;
  logic [5:0] po;
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
  logic [3:0] po_min;
`endif

  int checks;
  int failures;

  max_pair_cmp_reg #(
    .W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pi        (pi),
    .out_valid (out_valid),
    .po        (po)
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
    ,
    .po_min    (po_min)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector at the falling edge and move to just after the next rising edge.
  task automatic drive(input logic [7:0] v, input logic vld);
    @(negedge clk);
    pi       = v;
    in_valid = vld;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    pi       = 8'h00;
    #12;
    checks++;
    if (po !== 6'b000000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_initial po=%b ov=%b required po=000000 ov=0", po, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'hA5, 1'b1);
    checks++;
    if (po !== 6'b011010 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_prior po=%b ov=%b required po=011010 ov=1", po, out_valid);
    end
    // Mid-cycle asynchronous assertion, well clear of any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (po !== 6'b000000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async po=%b ov=%b required po=000000 ov=0", po, out_valid);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] vin [5];
    logic [5:0] vexp [5];
    vin  = '{8'h00, 8'h5A, 8'hA5, 8'hFF, 8'h77};
    vexp = '{6'b100000, 6'b001010, 6'b011010, 6'b101111, 6'b100111};
    for (int i = 0; i < 5; i++) begin
      drive(vin[i], 1'b1);
      checks++;
      if (po !== vexp[i] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL directed_%0d pi=%h po=%b ov=%b required po=%b ov=1", i, vin[i], po, out_valid, vexp[i]);
      end
      drive(8'h00, 1'b0);
    end
  endtask

  task automatic test_hold();
    drive(8'hA5, 1'b1);
    drive(8'h3C, 1'b0);
    checks++;
    if (po !== 6'b011010 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold po=%b ov=%b required po=011010 ov=0", po, out_valid);
    end
    drive(8'hxx, 1'b0);
    checks++;
    if (po !== 6'b011010 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL hold_x po=%b ov=%b required po=011010 ov=0", po, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vin [3];
    logic [5:0] vexp [3];
    vin  = '{8'h10, 8'h01, 8'h9E};
    vexp = '{6'b010001, 6'b000001, 6'b001110};
    for (int i = 0; i < 3; i++) begin
      drive(vin[i], 1'b1);
      checks++;
      if (po !== vexp[i] || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_%0d po=%b ov=%b required po=%b ov=1", i, po, out_valid, vexp[i]);
      end
    end
    drive(8'h00, 1'b0);
  endtask

  task automatic test_midstream_reset();
    drive(8'h5A, 1'b1);
    @(negedge clk);
    pi       = 8'hFF;
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (po !== 6'b000000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midstream_reset po=%b ov=%b required po=000000 ov=0", po, out_valid);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (po !== 6'b000000 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle po=%b ov=%b required po=000000 ov=0", po, out_valid);
    end
  endtask

  task automatic test_sweep();
    int         bad;
    logic [3:0] a;
    logic [3:0] b;
    logic [5:0] exp;
    logic [5:0] prev;
    bad  = 0;
    prev = po;
    for (int i = 0; i < 256; i++) begin
      a = i[7:4];
      b = i[3:0];
      if (a > b)       exp = {2'b01, a};
      else if (a == b) exp = {2'b10, a};
      else             exp = {2'b00, b};
      @(negedge clk);
      pi       = i[7:0];
      in_valid = 1'b1;
      // Nothing may change before the capturing edge.
      #3;
      if (po !== prev) bad++;
      @(posedge clk);
      #1;
      if (po !== exp || out_valid !== 1'b1) begin
        bad++;
        if (bad < 5) $display("FAIL sweep pi=%h po=%b required %b", i[7:0], po, exp);
      end
      prev = exp;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL sweep_total bad=%0d required 0", bad);
    end
    drive(8'h00, 1'b0);
  endtask

`ifdef MAX_PAIR_CMP_MIN_OUT_EN
  task automatic test_min();
    int         bad;
    logic [3:0] a;
    logic [3:0] b;
    drive(8'h5A, 1'b1);
    checks++;
    if (po_min !== 4'h5 || po !== 6'b001010) begin
      failures++;
      $display("FAIL min_5a po_min=%h po=%b required po_min=5 po=001010", po_min, po);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      a = i[7:4];
      b = i[3:0];
      drive(i[7:0], 1'b1);
      if (po_min !== ((a < b) ? a : b)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL min_sweep bad=%0d required 0", bad);
    end
    drive(8'h00, 1'b0);
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_midstream_reset();
    test_sweep();
`ifdef MAX_PAIR_CMP_MIN_OUT_EN
    test_min();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_pair_cmp_reg.md
Name: max_pair_cmp_reg

Overview:
- Registered 2-operand maximum selector and comparator. It is the synthesizable, clocked form of the 8-in/6-out partition slice max_48_1 from the "max" benchmark.
- The 8-bit input packs two unsigned operands, A = pi[7:4] and B = pi[3:0].
- The 6-bit output packs:
  - max(A,B)
  - an A-greater-than-B flag
  - an A-equal-B flag
- Sits in the partitioned max datapath and feeds wider max-tree stages.

Parameters:
- W, 4: operand width. pi is 2*W bits, po is W+2 bits. Legal range 1..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  pi is sampled on this clock edge when high.
- pi  input  2*W  packed operands; A = pi[2W-1:W], B = pi[W-1:0].
- out_valid  output  1  po holds a result computed from the last accepted pi.
- po  output  W+2  packed result:
  - po[W-1:0] = max(A,B)
  - po[W] = gt (A > B)
  - po[W+1] = eq (A == B)

Interface (already decided): one clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset: while rst_n = 0, po = 0 and out_valid = 0 immediately, independent of clk. Release is synchronous in effect: the first capture happens on the first rising clk edge with rst_n = 1.
- Latency: exactly 1 cycle. With in_valid = 1 at edge N, po and out_valid = 1 are visible after edge N.
- in_valid = 0 at an edge: out_valid goes 0 and po holds its previous value (no clear).
- No handshake or back-pressure. Every valid input is accepted; throughput is 1 result per cycle.
- Arithmetic:
  - Unsigned compare, full width, no overflow possible.
  - max = A when A >= B, else B.
  - gt and eq are mutually exclusive. gt = 0 and eq = 0 means A < B.
- Boundary cases:
  - A == B: max = A, eq = 1, gt = 0. This includes A = B = 0, which gives po = 6'b100000 for W = 4.
  - All-ones operands: max = all-ones.
- Reset asserted mid-stream: the result in flight is discarded, and out_valid is 0 until the next accepted input.
- No X propagation: po is reset-defined. When in_valid = 0, X on pi must not corrupt po.
- Combinational core is purely function-of-pi: for every 2^(2W) value the registered po equals the packed reference result.

Optional Feature:
- Macro MAX_PAIR_CMP_MIN_OUT_EN.
- Defined:
  - Adds output port po_min (W bits) = min(A,B).
  - po_min is registered under the same in_valid/reset rules as po; its reset value is 0.
- Undefined:
  - Port is absent and the logic is not generated.
  - po, out_valid and timing are identical in both builds.

Decomposition:
- Shared package max_pair_pkg holds:
  - localparam default W
  - result field offsets (MAX_LSB = 0, GT_BIT = W, EQ_BIT = W+1)
  - a packed struct typedef {eq, gt, max[W-1:0]} for po
- One sub-module is natural: max_pair_core.
  - Purely combinational.
  - Inputs a, b; outputs max, gt, eq (and min under the macro).
- The top module instantiates max_pair_core and owns the registers and valid logic.

Test Plan (W = 4):
- Reset: assert rst_n = 0 asynchronously mid-cycle with prior po = 6'b011010 -> po = 6'b000000 and out_valid = 0 immediately, without waiting for clk.
- Directed values, in_valid = 1, each checked one cycle later:
  - pi = 8'h00 -> po = 6'b100000
  - pi = 8'h5A -> po = 6'b001010
  - pi = 8'hA5 -> po = 6'b011010
  - pi = 8'hFF -> po = 6'b101111
  - pi = 8'h77 -> po = 6'b100111
- Hold: after pi = 8'hA5 accepted, drive in_valid = 0 with pi = 8'h3C -> po stays 6'b011010 and out_valid = 0.
- Back-to-back streaming: 8'h10, 8'h01, 8'h9E on consecutive cycles -> po = 6'b010001, 6'b000001, 6'b001110 on consecutive cycles.
- Exhaustive sweep: pi = 0..255 in order, in_valid = 1 -> each po matches the packed reference model, with exactly 1-cycle latency.
- With MAX_PAIR_CMP_MIN_OUT_EN defined: pi = 8'h5A -> po_min = 4'h5 and po = 6'b001010. Rerun the exhaustive sweep in both builds.
